// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl_pkg
// Description : Shared types and constants for the interrupt/trap sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        TRAP  = 3'd2,
        REDIR = 3'd3,
        RET   = 3'd4
    } state_t;

    localparam logic [4:0] CAUSE_MSI = 5'd3;
    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MEI = 5'd11;

    localparam int MIP_MSI_BIT = 3;
    localparam int MIP_MTI_BIT = 7;
    localparam int MIP_MEI_BIT = 11;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage
`default_nettype wire

// File: rtl/int_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : int_prio_enc
// Description : Pending-interrupt priority encoder, MEI > MSI > MTI.
// Revision    : 1.0 - initial release
// ============================================================================
module int_prio_enc
    import int_ctrl_pkg::*;
(
    input  logic [31:0] pending,
    output logic        any,
    output logic [4:0]  code
);

    always_comb begin
        any  = 1'b1;
        code = 5'd0;
        if (pending[MIP_MEI_BIT]) begin
            code = CAUSE_MEI;
        end else if (pending[MIP_MSI_BIT]) begin
            code = CAUSE_MSI;
        end else if (pending[MIP_MTI_BIT]) begin
            code = CAUSE_MTI;
        end else begin
            any = 1'b0;
        end
    end

    // Non-machine-level sources are deliberately ignored.
    logic w_unused_bits;
    assign w_unused_bits = ^{pending[31:12], pending[10:8], pending[6:4], pending[2:0]};

endmodule
`default_nettype wire

// File: rtl/int_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_trap_ctrl
// Description : Interrupt/trap sequencer: drain, commit, redirect, and mret.
//               Optional macro VECTORED_MODE_EN enables vectored mtvec mode.
// Revision    : 1.0 - initial release
// ============================================================================
module int_trap_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int DRAIN_MAX = 16,
    parameter int CNT_W     = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mip,
    input  logic [31:0] mie,
    input  logic        mie_global,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        mret_req,
    input  logic        pipe_drained,
    output logic        stall_req,
    output logic        int_action,
    output logic        ret_action,
    output logic        hw_int,
    output logic [4:0]  int_code,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        drain_timeout,
    output logic        busy
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DRAIN_MAX - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       w_pending;
    logic              w_any;
    logic [4:0]        w_pend_code;
    logic [31:0]       w_base;
    logic [31:0]       w_trap_pc;

    assign w_pending = mip & mie & {32{mie_global}};

    int_prio_enc u_prio_enc (
        .pending (w_pending),
        .any     (w_any),
        .code    (w_pend_code)
    );

    assign w_base = {mtvec[31:2], 2'b00};

`ifdef VECTORED_MODE_EN
    assign w_trap_pc = (mtvec[1:0] == MTVEC_MODE_VECTORED)
                     ? w_base + {25'd0, int_code, 2'b00}
                     : w_base;
`else
    logic w_unused_mode;
    assign w_unused_mode = ^mtvec[1:0];
    assign w_trap_pc     = w_base;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        stall_req      = 1'b0;
        int_action     = 1'b0;
        ret_action     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        drain_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                // mret first: the interrupt is re-evaluated once MIE is restored.
                if (mret_req) begin
                    w_state_nxt = RET;
                end else if (w_any) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                stall_req = 1'b1;
                if (!w_any) begin
                    w_state_nxt = IDLE;
                end else if (pipe_drained) begin
                    w_state_nxt = TRAP;
                end else if (r_cnt == C_CNT_LAST) begin
                    drain_timeout = 1'b1;
                    w_state_nxt   = TRAP;
                end
            end
            TRAP: begin
                stall_req   = 1'b1;
                int_action  = 1'b1;
                w_state_nxt = REDIR;
            end
            REDIR: begin
                stall_req      = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = w_trap_pc;
                w_state_nxt    = IDLE;
            end
            RET: begin
                ret_action     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = mepc;
                w_state_nxt    = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The cause is tracked live during DRAIN, so it is captured only on the
    // DRAIN->TRAP edge; int_code is then stable for the whole TRAP cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            int_code <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == DRAIN) ? r_cnt + CNT_W'(1) : '0;
            if (r_state == DRAIN && w_state_nxt == TRAP) begin
                int_code <= w_pend_code;
            end
        end
    end

    assign hw_int = 1'b1;
    assign busy   = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_int_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_trap_ctrl
// Description : Directed self-checking bench for int_trap_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_trap_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] mip;
    logic [31:0] mie;
    logic        mie_global;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mret_req;
    logic        pipe_drained;
    logic        stall_req;
    logic        int_action;
    logic        ret_action;
    logic        hw_int;
    logic [4:0]  int_code;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        drain_timeout;
    logic        busy;

    int checks;
    int errors;

`ifdef VECTORED_MODE_EN
    localparam logic [31:0] C_VEC_PC = 32'h0000_012C;
`else
    localparam logic [31:0] C_VEC_PC = 32'h0000_0100;
`endif

    int_trap_ctrl #(.DRAIN_MAX(16), .CNT_W(5)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mip            (mip),
        .mie            (mie),
        .mie_global     (mie_global),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .mret_req       (mret_req),
        .pipe_drained   (pipe_drained),
        .stall_req      (stall_req),
        .int_action     (int_action),
        .ret_action     (ret_action),
        .hw_int         (hw_int),
        .int_code       (int_code),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .drain_timeout  (drain_timeout),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic test_reset();
        reset_n = 1'b0; mip = 32'd0; mie = 32'h888; mie_global = 1'b1;
        mtvec = 32'h80; mepc = 32'd0; mret_req = 1'b0; pipe_drained = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
        checks++; if (hw_int !== 1'b1) begin errors++; $display("FAIL reset_hw_int: got %b expected 1", hw_int); end
        checks++; if (int_code !== 5'd0) begin errors++; $display("FAIL reset_int_code: got %0d expected 0", int_code); end
        checks++; if ({int_action, ret_action, redirect_valid, drain_timeout} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {int_action, ret_action, redirect_valid, drain_timeout}); end
        checks++; if (redirect_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", redirect_pc); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_timer_trap();
        mip = 32'h80; pipe_drained = 1'b1; mtvec = 32'h80;
        @(negedge clk); // DRAIN
        checks++; if ({stall_req, busy, int_action} !== 3'b110) begin errors++; $display("FAIL timer_drain: got %b expected 110", {stall_req, busy, int_action}); end
        @(negedge clk); // TRAP
        checks++; if (int_action !== 1'b1) begin errors++; $display("FAIL timer_int_action: got %b expected 1", int_action); end
        checks++; if (int_code !== 5'd7) begin errors++; $display("FAIL timer_int_code: got %0d expected 7", int_code); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL timer_early_redirect: got %b expected 0", redirect_valid); end
        mip = 32'd0;
        @(negedge clk); // REDIR
        checks++; if ({redirect_valid, int_action, stall_req} !== 3'b101) begin errors++; $display("FAIL timer_redirect: got %b expected 101", {redirect_valid, int_action, stall_req}); end
        checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL timer_redirect_pc: got %h expected 00000080", redirect_pc); end
        @(negedge clk); // IDLE
        checks++; if ({busy, redirect_valid} !== 2'b00) begin errors++; $display("FAIL timer_idle: got %b expected 00", {busy, redirect_valid}); end
        checks++; if (int_code !== 5'd7) begin errors++; $display("FAIL timer_code_hold: got %0d expected 7", int_code); end
    endtask

    task automatic test_priority();
        mip = 32'h888; pipe_drained = 1'b1;
        @(negedge clk); @(negedge clk); // TRAP
        checks++; if (int_code !== 5'd11) begin errors++; $display("FAIL prio_all: got %0d expected 11", int_code); end
        mip = 32'd0;
        @(negedge clk); @(negedge clk); // IDLE
        mip = 32'h888; pipe_drained = 1'b0;
        @(negedge clk); // DRAIN
        checks++; if (int_code !== 5'd11) begin errors++; $display("FAIL prio_code_stable: got %0d expected 11", int_code); end
        mip = 32'h088; pipe_drained = 1'b1;
        @(negedge clk); // TRAP
        checks++; if ({int_action, int_code} !== {1'b1, 5'd3}) begin errors++; $display("FAIL prio_relatch: got %b/%0d expected 1/3", int_action, int_code); end
        mip = 32'd0;
        @(negedge clk); @(negedge clk); // IDLE
    endtask

    task automatic test_drain_timeout();
        mip = 32'h80; pipe_drained = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) begin
                checks++; if (drain_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: cycle %0d got %b expected 0", i, drain_timeout); end
            end else begin
                checks++; if ({drain_timeout, stall_req} !== 2'b11) begin errors++; $display("FAIL timeout_pulse: got %b expected 11", {drain_timeout, stall_req}); end
            end
        end
        @(negedge clk); // TRAP
        checks++; if ({int_action, drain_timeout} !== 2'b10) begin errors++; $display("FAIL timeout_trap: got %b expected 10", {int_action, drain_timeout}); end
        mip = 32'd0;
        @(negedge clk); // REDIR
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL timeout_redirect: got %b expected 1", redirect_valid); end
        pipe_drained = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_withdrawn();
        mip = 32'h80; pipe_drained = 1'b0;
        @(negedge clk); @(negedge clk); // second DRAIN cycle
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL withdraw_stall: got %b expected 1", stall_req); end
        mip = 32'd0;
        @(negedge clk); // IDLE
        checks++; if ({stall_req, busy, int_action, redirect_valid} !== 4'b0000) begin errors++; $display("FAIL withdraw_idle: got %b expected 0000", {stall_req, busy, int_action, redirect_valid}); end
        @(negedge clk);
        checks++; if ({int_action, redirect_valid, int_code} !== {2'b00, 5'd7}) begin errors++; $display("FAIL withdraw_quiet: got %b/%0d expected 00/7", {int_action, redirect_valid}, int_code); end
        pipe_drained = 1'b1;
    endtask

    task automatic test_mret();
        mret_req = 1'b1; mip = 32'h800; mepc = 32'h1234; pipe_drained = 1'b1;
        @(negedge clk); // RET
        checks++; if ({ret_action, redirect_valid, int_action, busy} !== 4'b1101) begin errors++; $display("FAIL mret_strobes: got %b expected 1101", {ret_action, redirect_valid, int_action, busy}); end
        checks++; if (redirect_pc !== 32'h1234) begin errors++; $display("FAIL mret_pc: got %h expected 00001234", redirect_pc); end
        mret_req = 1'b0;
        @(negedge clk); // IDLE, interrupt still pending
        checks++; if ({ret_action, redirect_valid, busy} !== 3'b000) begin errors++; $display("FAIL mret_idle: got %b expected 000", {ret_action, redirect_valid, busy}); end
        @(negedge clk); // DRAIN
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL mret_then_drain: got %b expected 1", stall_req); end
        @(negedge clk); // TRAP
        checks++; if ({int_action, int_code} !== {1'b1, 5'd11}) begin errors++; $display("FAIL mret_then_trap: got %b/%0d expected 1/11", int_action, int_code); end
        mip = 32'd0;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_vectored();
        mtvec = 32'h101; mip = 32'h800; pipe_drained = 1'b1;
        @(negedge clk); @(negedge clk); // TRAP
        mip = 32'd0;
        @(negedge clk); // REDIR
        checks++; if ({redirect_valid, redirect_pc} !== {1'b1, C_VEC_PC}) begin errors++; $display("FAIL vectored_pc: got %b/%h expected 1/%h", redirect_valid, redirect_pc, C_VEC_PC); end
        @(negedge clk);
        mtvec = 32'h80;
    endtask

    task automatic test_reset_mid_drain();
        mip = 32'h80; pipe_drained = 1'b0;
        @(negedge clk); @(negedge clk); // DRAIN
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({stall_req, busy, int_action, ret_action, redirect_valid, drain_timeout} !== 6'b0) begin errors++; $display("FAIL midreset_outputs: got %b expected 000000", {stall_req, busy, int_action, ret_action, redirect_valid, drain_timeout}); end
        checks++; if (int_code !== 5'd0) begin errors++; $display("FAIL midreset_code: got %0d expected 0", int_code); end
        mip = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_release: got %b expected 0", busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_timer_trap();
        test_priority();
        test_drain_timeout();
        test_withdrawn();
        test_mret();
        test_vectored();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
